// File: rtl/f5_sweep_check.sv
// f5_sweep_check
// Clocked stimulus-and-check sweep around the f5 pair (s = ~a & b). The block
// drives each {x, y} vector in turn into both f5 instances. It holds each
// vector for SETTLE cycles, samples both instance outputs in a one-cycle
// CHECK state and compares them with the golden value. It then reports a
// saturating error count and the first failing vector.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          sweep request, accepted only in IDLE or DONE
//   x, y           stimulus to both f5 instances (x = vector MSB)
//   a_in           output of the gate-level f5 instance
//   b_in           output of the expression f5 instance
//   busy           sweep in progress
//   done           sweep finished, held until the next accepted start
//   err_cnt        number of failing vectors, saturating
//   err_flag       at least one vector failed in the last sweep
//   first_err_vec  {x, y} of the first failing vector (valid when err_flag)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | holding the current vector for SETTLE cycles
// CHECK | one cycle; a_in/b_in are sampled at its closing edge
// DONE  | sweep finished, results held, waiting for start

module f5_sweep_check #(
   parameter int SETTLE = 1,
   parameter int ERR_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             x,
   output logic             y,
   input  logic             a_in,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_cnt,
   output logic             err_flag,
   output logic [1:0]       first_err_vec
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int              WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   logic [1:0]        state;
   logic [1:0]        vec;
   logic [WAIT_W-1:0] wait_cnt;
   logic              exp_s;
   logic              vec_fail;

   // The vector register drives x/y directly, so the stimulus stays registered.
   assign x = vec[1];
   assign y = vec[0];

   assign exp_s    = ~vec[1] & vec[0];
   // A mismatch between a_in and b_in always shows up as one of them
   // disagreeing with the golden value, so no separate pair compare is needed.
   assign vec_fail = (a_in != exp_s) || (b_in != exp_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         vec           <= 2'b00;
         wait_cnt      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_vec <= 2'b00;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state         <= ST_WAIT;
                  vec           <= 2'b00;
                  wait_cnt      <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  err_cnt       <= '0;
                  err_flag      <= 1'b0;
                  first_err_vec <= 2'b00;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= ST_CHECK;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_CHECK: begin
               if (vec_fail) begin
                  if (err_cnt != ERR_MAX) begin
                     err_cnt <= err_cnt + ERR_W'(1);
                  end
                  if (!err_flag) begin
                     err_flag      <= 1'b1;
                     first_err_vec <= vec;
                  end
               end
               if (vec == 2'b11) begin
                  // x/y keep the last vector while results are held.
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= ST_WAIT;
                  vec      <= vec + 2'b01;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/f5_sweep_check.md
Name: f5_sweep_check

Overview:
- Sequential stimulus-and-check stage wrapped around the f5 pair (gate-level and expression forms of s = ~a & b).
- Upstream role: drives every (x, y) input combination into both f5 instances.
- Downstream role: samples both instance outputs and compares them against the golden value and against each other.
- Replaces the hand-written #1 stimulus sequence with a clocked, self-checking sweep that reports an error count and the first failing vector.

Parameters:
- SETTLE, 1, cycles x/y are held before outputs are sampled (legal range >= 1).
- ERR_W, 3, width of the error counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE or DONE.
- x  output  1  stimulus to both f5 instances (vector MSB).
- y  output  1  stimulus to both f5 instances (vector LSB).
- a_in  input  1  output of the gate-level f5 instance.
- b_in  input  1  output of the expression f5 instance.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until the next accepted start or reset.
- err_cnt  output  ERR_W  number of failing vectors, saturating.
- err_flag  output  1  high if any vector failed in the last sweep.
- first_err_vec  output  2  {x, y} of the first failing vector; valid only when err_flag = 1.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; state IDLE; vector counter 0; wait counter 0. Reset mid-sweep aborts immediately; no partial results are kept.
- States:
  - IDLE, DONE: on start=1, go to WAIT. At that edge: vec=0, {x, y}=00, wait counter=0, err_cnt=0, err_flag=0, first_err_vec=0, busy=1, done=0.
  - WAIT: wait counter increments each cycle. When it equals SETTLE-1, go to CHECK.
  - CHECK: lasts one cycle and samples a_in and b_in at its closing edge.
    - exp = ~x & y.
    - The vector fails if a_in != exp or b_in != exp (this also covers a_in != b_in).
    - On failure: err_cnt increments, holding at 2^ERR_W-1 once it is reached. If err_flag was 0, latch first_err_vec={x, y} and set err_flag=1.
    - If vec==3: go to DONE, busy=0, done=1; x and y hold their last value.
    - Otherwise: vec increments, {x, y}=vec+1, wait counter=0, go to WAIT.
- Vector order: 00, 01, 10, 11. x is the MSB.
- Timing: each vector is driven for exactly SETTLE+1 cycles. done rises 4*(SETTLE+1) rising edges after the edge that accepted start.
- start while busy=1 is ignored and has no effect on the sweep.
- start in DONE restarts the sweep and clears all results at the accepting edge. The previous results stay visible up to that edge.
- The whole block is registered; no output is combinational from any input.

Test Plan:
- Correct DUT pair, SETTLE=1; pulse start → x/y step 00, 01, 10, 11 every 2 cycles; done=1 exactly 8 edges after start; err_cnt=0; err_flag=0.
- b_in tied to 0, a_in correct → only vector 01 fails; err_cnt=1, err_flag=1, first_err_vec=01.
- a_in tied to 1, b_in correct, ERR_W=3 → vectors 00, 10 and 11 fail; err_cnt=3, first_err_vec=00.
- ERR_W=1 with a_in tied to 1 → err_cnt saturates at 1; err_flag=1; first_err_vec=00.
- start pulsed again during the sweep (vector 10) → no restart, same 8-cycle timing. Then start in DONE with a correct DUT → results clear to 0; done reasserts after 8 edges.
- rst_n=0 asynchronously during vector 01 → busy, done, x, y, err_cnt, err_flag and first_err_vec all read 0 before the next clock edge; after release, state is IDLE and the block waits for start.
